// File: rtl/intlv_rd_ctrl_pkg.sv
// rtl/intlv_rd_ctrl_pkg.sv - shared states, PB geometry and step constants for the interleaver read-out
package intlv_rd_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam int unsigned LEN_PB16   = 32'h040;
  localparam int unsigned LEN_PB136  = 32'h220;
  localparam int unsigned LEN_PB520  = 32'h820;

  localparam int unsigned BASE_PB16  = 32'h000;
  localparam int unsigned BASE_PB136 = 32'h040;
  localparam int unsigned BASE_PB520 = 32'h260;

  localparam int unsigned STEP_PB16  = 5;
  localparam int unsigned STEP_PB136 = 13;
  localparam int unsigned STEP_PB520 = 7;

  localparam int unsigned BUF_DEPTH  = 2688;

  function automatic logic len_is_legal(input int unsigned len);
    return (len == LEN_PB16) || (len == LEN_PB136) || (len == LEN_PB520);
  endfunction

  // Each step is coprime with its length, so perm visits every word exactly once.
  function automatic int unsigned step_for(input int unsigned len);
    case (len)
      LEN_PB136: return STEP_PB136;
      LEN_PB520: return STEP_PB520;
      default:   return STEP_PB16;
    endcase
  endfunction

endpackage

// File: rtl/intlv_rd_ctrl_if.sv
// rtl/intlv_rd_ctrl_if.sv - write-enable generator side and decoder side signals of the read-out controller
interface intlv_rd_ctrl_if #(
  parameter int DW = 6,
  parameter int AW = 12
);

  logic [AW-1:0] len_l;
  logic          wen;
  logic [AW-1:0] enable;
  logic [AW-1:0] pb_offset;
  logic          done;
  logic [DW-1:0] din;

  logic [DW-1:0] dout;
  logic          dout_vld;
  logic          dout_last;
  logic          frame_done;
  logic          err;

  modport master (
    output len_l, wen, enable, pb_offset, done, din,
    input  dout, dout_vld, dout_last, frame_done, err
  );

  modport slave (
    input  len_l, wen, enable, pb_offset, done, din,
    output dout, dout_vld, dout_last, frame_done, err
  );

endinterface

// File: rtl/intlv_ram.sv
// rtl/intlv_ram.sv - simple dual-port buffer RAM, registered read with one cycle latency
module intlv_ram #(
  parameter int DW    = 6,
  parameter int AW    = 12,
  parameter int DEPTH = 2688
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // No reset here so the array and read register map onto block RAM.
  always_ff @(posedge clk) begin
    if (we && (32'(waddr) < 32'(DEPTH))) begin
      mem[waddr] <= wdata;
    end
    if (re && (32'(raddr) < 32'(DEPTH))) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/intlv_rd_ctrl.sv
// rtl/intlv_rd_ctrl.sv - captures one PB into the buffer and streams it back in interleaved order
module intlv_rd_ctrl
  import intlv_rd_ctrl_pkg::*;
#(
  parameter int DW    = 6,
  parameter int AW    = 12,
  parameter int DEPTH = 2688
) (
  input  logic         clk,
  input  logic         rst,
  intlv_rd_ctrl_if.slave bus
);

  state_t        state;
  logic          done_q;
  logic          done_q2;
  logic [AW-1:0] len_r;
  logic [AW-1:0] base_r;
  logic [AW-1:0] step_r;
  logic [AW-1:0] perm;
  logic [AW-1:0] cnt;
  logic          flush_cnt;
  logic          rd_vld_d1;
  logic          rd_last_d1;

  logic          len_ok;
  logic          done_rise;
  logic          wr_en;
  logic [AW-1:0] waddr;
  logic          rd_en;
  logic          rd_last;
  logic [AW-1:0] raddr;
  logic [AW-1:0] perm_sum;
  logic [AW-1:0] perm_next;
  logic [DW-1:0] rd_data;

  assign len_ok    = len_is_legal(32'(bus.len_l));
  assign done_rise = done_q & ~done_q2;

  assign wr_en = bus.wen && ((state == FILL) || ((state == IDLE) && len_ok));
  assign waddr = bus.pb_offset + bus.enable;

  assign rd_en   = (state == DRAIN);
  assign rd_last = rd_en && (cnt == (len_r - AW'(1)));
  assign raddr   = base_r + perm;

  // step < len, so one conditional subtract keeps perm inside [0, len).
  assign perm_sum  = perm + step_r;
  assign perm_next = (perm_sum >= len_r) ? (perm_sum - len_r) : perm_sum;

  intlv_ram #(
    .DW    (DW),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (waddr),
    .wdata (bus.din),
    .re    (rd_en),
    .raddr (raddr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      done_q         <= 1'b0;
      done_q2        <= 1'b0;
      len_r          <= '0;
      base_r         <= '0;
      step_r         <= '0;
      perm           <= '0;
      cnt            <= '0;
      flush_cnt      <= 1'b0;
      rd_vld_d1      <= 1'b0;
      rd_last_d1     <= 1'b0;
      bus.dout       <= '0;
      bus.dout_vld   <= 1'b0;
      bus.dout_last  <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      done_q  <= bus.done;
      done_q2 <= done_q;

      // Read pipeline: RAM register, then output register.
      rd_vld_d1     <= rd_en;
      rd_last_d1    <= rd_last;
      bus.dout_vld  <= rd_vld_d1;
      bus.dout_last <= rd_last_d1;
      bus.dout      <= rd_vld_d1 ? rd_data : '0;

      bus.frame_done <= 1'b0;
      bus.err        <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.wen) begin
            if (len_ok) begin
              state <= FILL;
            end else begin
              bus.err <= 1'b1;
            end
          end
        end

        FILL: begin
          if (done_rise) begin
            state  <= DRAIN;
            len_r  <= bus.len_l;
            base_r <= bus.pb_offset;
            step_r <= AW'(step_for(32'(bus.len_l)));
            perm   <= '0;
            cnt    <= '0;
          end
        end

        DRAIN: begin
          if (bus.wen) begin
            bus.err <= 1'b1;
          end
          perm <= perm_next;
          cnt  <= cnt + AW'(1);
          if (rd_last) begin
            state     <= FLUSH;
            flush_cnt <= 1'b0;
          end
        end

        FLUSH: begin
          if (bus.wen) begin
            bus.err <= 1'b1;
          end
          flush_cnt <= 1'b1;
          if (flush_cnt) begin
            bus.frame_done <= 1'b1;
            state          <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
